uart_frame_parser: RTL
======================

Name: uart_frame_parser

Overview:
- Downstream consumer of the UART receive FIFO. Pops bytes through the FIFO read port and hunts for a sync byte.
- Parses frames of the form SYNC, LEN, LEN payload bytes, CHK.
- Streams payload bytes to the application with a valid/ready handshake, then flags each frame as good or bad.
- Keeps saturating counters of good and bad frames.

Parameters:
- DATA_WIDTH, 8, byte width; must match the FIFO.
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_PAYLOAD, 64, largest legal LEN value.
- TIMEOUT_CYCLES, 100_000, inter-byte timeout in clocks; used only with the optional feature.

Ports:
- CLKip  input  1  clock
- RSTi  input  1  asynchronous reset, active-high
- RDo  output  1  FIFO read strobe, one cycle per byte
- DATAi  input  DATA_WIDTH  FIFO read data, valid the cycle after RDo
- EMPTYi  input  1  FIFO empty flag
- PAY_DATAo  output  DATA_WIDTH  payload byte
- PAY_VALIDo  output  1  payload byte valid
- PAY_LASTo  output  1  marks the final payload byte of a frame
- PAY_READYi  input  1  downstream accepts payload byte
- FRAME_OKo  output  1  one-cycle pulse: checksum good
- FRAME_ERRo  output  1  one-cycle pulse: frame rejected
- ERR_CODEo  output  2  01 bad LEN, 10 bad CHK, 11 timeout; held until the next FRAME_ERRo
- OK_CNTo  output  16  good-frame count, saturating at 16'hFFFF
- ERR_CNTo  output  16  bad-frame count, saturating at 16'hFFFF

Behaviour:
- Reset: all outputs 0, state HUNT, checksum 0, byte counter 0, no read pending. Reset mid-frame discards the partial frame; FIFO contents are untouched.
- Read sequencing:
  - RDo = !EMPTYi & !pend & !hold.
  - pend is set the cycle RDo is high; the byte is captured from DATAi on the next cycle, which also clears pend.
  - Maximum rate is one byte per 2 clocks.
  - hold is true while PAY_VALIDo is high and PAY_READYi is low.
- HUNT state:
  - Captured byte equal to SYNC_BYTE: go to LEN, clear checksum.
  - Any other byte: dropped, stay in HUNT.
- LEN state:
  - Captured L with 1 <= L <= MAX_PAYLOAD: checksum = L, counter = L, go to PAY.
  - Any other L (including 0): FRAME_ERRo pulse, ERR_CODEo = 01, go to HUNT.
  - The rejected LEN byte is not re-examined as a possible sync byte.
- PAY state:
  - Each captured byte is presented on PAY_DATAo with PAY_VALIDo = 1 and held until PAY_READYi = 1.
  - checksum += byte, mod 256; counter decrements on acceptance.
  - PAY_LASTo = 1 with the byte for which counter == 1.
  - After the last byte is accepted, go to CHK.
- CHK state:
  - Captured byte equal to checksum: FRAME_OKo pulse, increment OK_CNTo.
  - Otherwise: FRAME_ERRo pulse, ERR_CODEo = 10, increment ERR_CNTo.
  - Either way, go to HUNT.
- Error counting: every FRAME_ERRo, including bad LEN, increments ERR_CNTo. Both counters saturate and do not wrap.
- FRAME_OKo and FRAME_ERRo are never high in the same cycle.
- Payload already delivered before a CHK error is not retracted; the consumer discards it on FRAME_ERRo.
- EMPTYi high in any state: no read, state held, no timeout counting unless the feature below is enabled.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined:
  - A counter runs while the state is LEN, PAY or CHK and no byte is captured; it clears on every capture.
  - Reaching TIMEOUT_CYCLES: FRAME_ERRo pulse, ERR_CODEo = 11, increment ERR_CNTo, go to HUNT.
  - A stalled PAY_READYi (hold) does not advance the counter.
- Undefined: no counter logic is present, the parser waits indefinitely, and code 11 never occurs.

Test Plan:
- FIFO holds A5 03 10 20 30 63, PAY_READYi = 1 -> PAY_DATAo 10, 20, 30 with PAY_LASTo on 30; FRAME_OKo pulses once; OK_CNTo = 1, ERR_CNTo = 0.
- Bytes 00 FF A5 01 7E 7F -> 00 and FF dropped; payload 7E delivered; FRAME_OKo pulses.
- Bytes A5 02 11 22 00 -> payload 11, 22 delivered; FRAME_ERRo pulses with ERR_CODEo = 10; ERR_CNTo = 1.
- Bytes A5 00, then A5 41 (LEN 65 > 64) -> two FRAME_ERRo pulses, each with ERR_CODEo = 01; state HUNT; no PAY_VALIDo.
- Good 4-byte frame with PAY_READYi low for 10 cycles on byte 2 -> PAY_DATAo stable, RDo held low, no byte lost; FRAME_OKo pulses.
- With UART_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES = 50: send A5 05 01, then FIFO stays empty -> FRAME_ERRo pulses at cycle 50 after the last capture with ERR_CODEo = 11. A following good frame then gives FRAME_OKo.
- Assert RSTi mid-PAY -> all outputs 0 and state HUNT.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: consumes bytes from the UART receive FIFO, hunts for the
// sync byte and parses SYNC, LEN, LEN payload bytes, CHK frames. Payload bytes
// go out on a valid/ready stream. Each frame ends with a one-cycle good or bad
// pulse, and saturating counters track good and bad frames.
// Optional build macro: UART_FRAME_TIMEOUT_EN adds an inter-byte timeout that
// aborts a frame stuck in LEN, PAY or CHK for TIMEOUT_CYCLES clocks.
module uart_frame_parser #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 'hA5,
    parameter int                    MAX_PAYLOAD    = 64,
    parameter int                    TIMEOUT_CYCLES = 100_000
) (
    input  logic                  CLKip,
    input  logic                  RSTi,
    output logic                  RDo,
    input  logic [DATA_WIDTH-1:0] DATAi,
    input  logic                  EMPTYi,
    output logic [DATA_WIDTH-1:0] PAY_DATAo,
    output logic                  PAY_VALIDo,
    output logic                  PAY_LASTo,
    input  logic                  PAY_READYi,
    output logic                  FRAME_OKo,
    output logic                  FRAME_ERRo,
    output logic [1:0]            ERR_CODEo,
    output logic [15:0]           OK_CNTo,
    output logic [15:0]           ERR_CNTo
);

    // LEN must fit in one byte; the timeout needs at least two cycles to count.
    generate
        if (MAX_PAYLOAD < 1 || MAX_PAYLOAD >= (1 << DATA_WIDTH) || TIMEOUT_CYCLES < 2) begin : g_bad_params
            $error("uart_frame_parser: MAX_PAYLOAD or TIMEOUT_CYCLES out of range");
        end
    endgenerate

    localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(MAX_PAYLOAD);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    localparam logic [1:0] CODE_BAD_LEN = 2'b01;
    localparam logic [1:0] CODE_BAD_CHK = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_LEN  = 2'd1,
        S_PAY  = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pay_data_q, pay_data_d;
    logic                  pay_valid_q, pay_valid_d;
    logic                  pay_last_q, pay_last_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  frame_err_q, frame_err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [15:0]           ok_cnt_q, ok_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;

    logic hold;
    logic rd;
    logic capture;
    logic accept;
    logic len_ok;
    logic tmo_fire;

    // A presented byte that is not yet taken blocks further FIFO reads, so at
    // most one payload byte is ever in flight. Reads are suppressed in reset
    // so the FIFO is left untouched.
    assign hold    = pay_valid_q & ~PAY_READYi;
    assign rd      = ~RSTi & ~EMPTYi & ~pend_q & ~hold;
    assign capture = pend_q;
    assign accept  = pay_valid_q & PAY_READYi;
    assign len_ok  = (DATAi != '0) && (DATAi <= MAX_LEN);
    assign pend_d  = rd;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_advance;

    // Idle clocks inside a frame; a stalled consumer is not the sender's fault.
    assign tmo_advance = (state_q != S_HUNT) && !capture && !hold;
    assign tmo_fire    = tmo_advance && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Inter-byte timeout counter: clears on every captured byte and outside a frame.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_HUNT || capture || tmo_fire) begin
            tmo_d = '0;
        end else if (tmo_advance) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advance on captured bytes, leave PAY when the last
    // payload byte has been accepted downstream.
    always_comb begin
        state_d = state_q;
        if (tmo_fire) begin
            state_d = S_HUNT;
        end else begin
            case (state_q)
                S_HUNT: if (capture && DATAi == SYNC_BYTE) state_d = S_LEN;
                S_LEN:  if (capture) state_d = len_ok ? S_PAY : S_HUNT;
                S_PAY:  if (accept && cnt_q == CNT_ONE) state_d = S_CHK;
                S_CHK:  if (capture) state_d = S_HUNT;
                default: state_d = S_HUNT;
            endcase
        end
    end

    // Datapath and outputs: payload presentation, running checksum, remaining
    // byte count, result pulses and saturating counters.
    always_comb begin
        pay_data_d  = pay_data_q;
        pay_valid_d = pay_valid_q;
        pay_last_d  = pay_last_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        ok_cnt_d    = ok_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (accept) begin
            pay_valid_d = 1'b0;
            pay_last_d  = 1'b0;
            cnt_d       = cnt_q - CNT_ONE;
        end

        if (tmo_fire) begin
            pay_valid_d = 1'b0;
            pay_last_d  = 1'b0;
            frame_err_d = 1'b1;
            err_code_d  = CODE_TIMEOUT;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (capture && DATAi == SYNC_BYTE) chk_d = '0;
                end
                S_LEN: begin
                    if (capture) begin
                        if (len_ok) begin
                            chk_d = DATAi;
                            cnt_d = DATAi;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = CODE_BAD_LEN;
                            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                end
                S_PAY: begin
                    // A capture never overlaps an unaccepted byte, so cnt_q
                    // still counts the byte being captured.
                    if (capture) begin
                        pay_data_d  = DATAi;
                        pay_valid_d = 1'b1;
                        pay_last_d  = (cnt_q == CNT_ONE);
                        chk_d       = chk_q + DATAi;
                    end
                end
                S_CHK: begin
                    if (capture) begin
                        if (DATAi == chk_q) begin
                            frame_ok_d = 1'b1;
                            if (ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = CODE_BAD_CHK;
                            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            pend_q      <= 1'b0;
            pay_data_q  <= '0;
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            chk_q       <= '0;
            cnt_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
            ok_cnt_q    <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            pend_q      <= pend_d;
            pay_data_q  <= pay_data_d;
            pay_valid_q <= pay_valid_d;
            pay_last_q  <= pay_last_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign RDo        = rd;
    assign PAY_DATAo  = pay_data_q;
    assign PAY_VALIDo = pay_valid_q;
    assign PAY_LASTo  = pay_last_q;
    assign FRAME_OKo  = frame_ok_q;
    assign FRAME_ERRo = frame_err_q;
    assign ERR_CODEo  = err_code_q;
    assign OK_CNTo    = ok_cnt_q;
    assign ERR_CNTo   = err_cnt_q;

endmodule
